// File: rtl/pipeline_hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - md_state_e   : mult/div sequencer state encoding (RUN / MD_BUSY)
//   - ZERO_REG     : architectural zero register index ($zero)
//   - REG_W_DEFAULT: default register-index width
//   - MD_CNT_W     : width of the mult/div busy counter
//   - md_load_value: counter preload for a given mult/div latency
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

  localparam int REG_W_DEFAULT = 5;
  localparam int MD_CNT_W      = 4;

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic {
    RUN     = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // The counter runs from latency-1 down to 0, so MD_BUSY lasts exactly
  // 'latency' cycles.
  function automatic logic [MD_CNT_W-1:0] md_load_value(input int latency);
    int unsigned v;
    v = unsigned'(latency - 1);
    return v[MD_CNT_W-1:0];
  endfunction

endpackage : hazard_ctrl_pkg

// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundle between the datapath (master) and the hazard controller (slave).
//   Decode-stage fields : IDrs, IDrt, IDUsesRs, IDUsesRt, IDReadHILO, IDMulDiv
//   Execute-stage fields: EXMemRead, EXrt
//   Branch resolution   : BranchTaken
//   Pipeline controls   : PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if
  import hazard_ctrl_pkg::*;
#(
  parameter int REG_W = REG_W_DEFAULT
);

  logic [REG_W-1:0] IDrs;
  logic [REG_W-1:0] IDrt;
  logic             IDUsesRs;
  logic             IDUsesRt;
  logic             IDReadHILO;
  logic             IDMulDiv;
  logic             EXMemRead;
  logic [REG_W-1:0] EXrt;
  logic             BranchTaken;

  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXBubble;
  logic             MDBusy;

  // Datapath side: supplies decoded fields, consumes pipeline controls.
  modport master (
    output IDrs, IDrt, IDUsesRs, IDUsesRt, IDReadHILO, IDMulDiv,
    output EXMemRead, EXrt, BranchTaken,
    input  PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy
  );

  // Controller side.
  modport slave (
    input  IDrs, IDrt, IDUsesRs, IDUsesRt, IDReadHILO, IDMulDiv,
    input  EXMemRead, EXrt, BranchTaken,
    output PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy
  );

endinterface : pipeline_hazard_ctrl_if

// File: rtl/pipeline_hazard_ctrl_md_busy_timer.sv
// -----------------------------------------------------------------------------
// md_busy_timer
// Tracks occupancy of the multi-cycle mult/div unit. An accepted issue in RUN
// moves to MD_BUSY for exactly MD_LATENCY cycles, then back to RUN. Issue
// requests seen while busy are ignored; the controller holds them in ID.
// Ports:
//   Clk        in  pipeline clock
//   Rst        in  synchronous active-low reset (aborts any wait)
//   i_issue    in  a mult/div leaves ID this cycle (only honoured in RUN)
//   o_md_busy  out state == MD_BUSY
// -----------------------------------------------------------------------------
module md_busy_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_issue,
  output logic o_md_busy
);

  if (MD_LATENCY < 1 || MD_LATENCY > 15) begin : g_bad_latency
    $error("md_busy_timer: MD_LATENCY must be in 1..15");
  end

  localparam logic [MD_CNT_W-1:0] LOAD_VAL = md_load_value(MD_LATENCY);

  md_state_e           r_state;
  md_state_e           w_state_nxt;
  logic [MD_CNT_W-1:0] r_count;
  logic [MD_CNT_W-1:0] w_count_nxt;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours; reset here is synchronous, so it
  // lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state <= RUN;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  // NOTE: every variable gets a hold value before the case statement so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    unique case (r_state)
      RUN: begin
        if (i_issue) begin
          w_state_nxt = MD_BUSY;
          w_count_nxt = LOAD_VAL;
        end
      end
      MD_BUSY: begin
        // The decrement is skipped at zero, so the counter never wraps.
        if (r_count == '0) begin
          w_state_nxt = RUN;
        end else begin
          w_count_nxt = r_count - 1'b1;
        end
      end
      default: begin
        w_state_nxt = RUN;
        w_count_nxt = '0;
      end
    endcase
  end

  assign o_md_busy = (r_state == MD_BUSY);

endmodule : md_busy_timer

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Hazard and sequencing controller for the 5-stage MIPS pipeline. Produces the
// PC / IF-ID / ID-EX controls for load-use stalls, mult/div busy stalls and
// taken-branch flushes. Controls are combinational from inputs and the
// mult/div timer state.
// Ports:
//   Clk   in   pipeline clock
//   Rst   in   synchronous active-low reset; forces safe controls while low
//   bus   slave modport of pipeline_hazard_ctrl_if (decoded fields in,
//         PCWrite / IFIDWrite / IFIDFlush / IDEXBubble / MDBusy out)
//   StallCount, FlushCount out [31:0] saturating performance counters,
//         present only when HAZARD_PERF_CNT_EN is defined.
// Priority: reset > load-use > mult/div stall > branch flush.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 4,
  parameter int REG_W      = REG_W_DEFAULT
) (
  input  logic                   Clk,
  input  logic                   Rst,
  pipeline_hazard_ctrl_if.slave  bus
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]            StallCount,
  output logic [31:0]            FlushCount
`endif
);

  logic [REG_W-1:0] w_id_rs;
  logic [REG_W-1:0] w_id_rt;
  logic [REG_W-1:0] w_ex_rt;
  logic             w_rs_hit;
  logic             w_rt_hit;
  logic             w_load_use;
  logic             w_md_busy;
  logic             w_md_stall;
  logic             w_stall;
  logic             w_issue;

  assign w_id_rs = bus.IDrs;
  assign w_id_rt = bus.IDrt;
  assign w_ex_rt = bus.EXrt;

  assign w_rs_hit   = bus.IDUsesRs && (w_id_rs == w_ex_rt);
  assign w_rt_hit   = bus.IDUsesRt && (w_id_rt == w_ex_rt);
  // A load into $zero produces nothing to wait for.
  assign w_load_use = bus.EXMemRead && (w_ex_rt != REG_W'(ZERO_REG))
                      && (w_rs_hit || w_rt_hit);

  assign w_md_stall = w_md_busy && (bus.IDReadHILO || bus.IDMulDiv);
  assign w_stall    = w_load_use || w_md_stall;

  // A mult/div leaves ID unless a load-use hazard holds it. While busy the
  // timer ignores this, and the same instruction is held by w_md_stall.
  assign w_issue = bus.IDMulDiv && !w_load_use;

  md_busy_timer #(
    .MD_LATENCY (MD_LATENCY)
  ) u_md_busy_timer (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_issue   (w_issue),
    .o_md_busy (w_md_busy)
  );

  always_comb begin
    bus.PCWrite    = 1'b1;
    bus.IFIDWrite  = 1'b1;
    bus.IFIDFlush  = 1'b0;
    bus.IDEXBubble = 1'b0;
    bus.MDBusy     = w_md_busy;
    if (!Rst) begin
      // Reset state may still read MD_BUSY until the edge; mask it here.
      bus.PCWrite    = 1'b0;
      bus.IFIDWrite  = 1'b0;
      bus.IFIDFlush  = 1'b1;
      bus.IDEXBubble = 1'b1;
      bus.MDBusy     = 1'b0;
    end else if (w_stall) begin
      // A branch in ID is held, not flushed; it re-resolves after the stall.
      bus.PCWrite    = 1'b0;
      bus.IFIDWrite  = 1'b0;
      bus.IDEXBubble = 1'b1;
    end else begin
      bus.IFIDFlush  = bus.BranchTaken;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_stall && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
      if (bus.IFIDFlush && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign StallCount = r_stall_count;
  assign FlushCount = r_flush_count;
`endif

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed bench for pipeline_hazard_ctrl. The main instance uses
// MD_LATENCY=4; a second instance with MD_LATENCY=1 shares the same inputs.
// Control vector layout: {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, MDBusy}.
// Inputs change 1ns after posedge; outputs are sampled at negedge.
// Build with +define+HAZARD_PERF_CNT_EN to also exercise the counters.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam logic [4:0] C_RST    = 5'b00110;
  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_LU     = 5'b00010;
  localparam logic [4:0] C_MDST   = 5'b00011;
  localparam logic [4:0] C_BUSY   = 5'b11001;
  localparam logic [4:0] C_BR     = 5'b11100;
  localparam logic [4:0] C_BRBUSY = 5'b11101;

  logic Clk;
  logic Rst;
  int   n_cmp;
  int   n_mis;

  pipeline_hazard_ctrl_if #(.REG_W(5)) bus  ();
  pipeline_hazard_ctrl_if #(.REG_W(5)) bus1 ();

  assign bus1.IDrs        = bus.IDrs;
  assign bus1.IDrt        = bus.IDrt;
  assign bus1.IDUsesRs    = bus.IDUsesRs;
  assign bus1.IDUsesRt    = bus.IDUsesRt;
  assign bus1.IDReadHILO  = bus.IDReadHILO;
  assign bus1.IDMulDiv    = bus.IDMulDiv;
  assign bus1.EXMemRead   = bus.EXMemRead;
  assign bus1.EXrt        = bus.EXrt;
  assign bus1.BranchTaken = bus.BranchTaken;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt, stall_cnt1, flush_cnt1;
`endif

  pipeline_hazard_ctrl #(.MD_LATENCY(4), .REG_W(5)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount (stall_cnt),
    .FlushCount (flush_cnt)
`endif
  );

  pipeline_hazard_ctrl #(.MD_LATENCY(1), .REG_W(5)) dut1 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus1)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCount (stall_cnt1),
    .FlushCount (flush_cnt1)
`endif
  );

  logic [4:0] ctl, ctl1;
  assign ctl  = {bus.PCWrite,  bus.IFIDWrite,  bus.IFIDFlush,  bus.IDEXBubble,  bus.MDBusy};
  assign ctl1 = {bus1.PCWrite, bus1.IFIDWrite, bus1.IFIDFlush, bus1.IDEXBubble, bus1.MDBusy};

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.IDrs        = '0;
    bus.IDrt        = '0;
    bus.IDUsesRs    = 1'b0;
    bus.IDUsesRt    = 1'b0;
    bus.IDReadHILO  = 1'b0;
    bus.IDMulDiv    = 1'b0;
    bus.EXMemRead   = 1'b0;
    bus.EXrt        = '0;
    bus.BranchTaken = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.IDrs        = 5'($urandom);
      bus.IDrt        = 5'($urandom);
      bus.IDUsesRs    = 1'($urandom);
      bus.IDUsesRt    = 1'($urandom);
      bus.IDReadHILO  = 1'($urandom);
      bus.IDMulDiv    = 1'($urandom);
      bus.EXMemRead   = 1'($urandom);
      bus.EXrt        = 5'($urandom);
      bus.BranchTaken = 1'($urandom);
      @(negedge Clk);
      n_cmp++;
      if (ctl !== C_RST) begin
        n_mis++;
        $display("FAIL reset_hold[%0d]: got %b want %b", i, ctl, C_RST);
      end
      next_cycle();
    end
    Rst = 1'b1;
    idle();
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL reset_release: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
  endtask

  task automatic test_load_use();
    idle();
    bus.EXMemRead = 1'b1; bus.EXrt = 5'd8; bus.IDrs = 5'd8; bus.IDUsesRs = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_LU) begin
      n_mis++;
      $display("FAIL load_use_rs: got %b want %b", ctl, C_LU);
    end
    next_cycle();
    bus.EXMemRead = 1'b0;   // load has moved on; dependant proceeds
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL load_use_release: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    bus.EXMemRead = 1'b1; bus.EXrt = 5'd0; bus.IDrs = 5'd0;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL load_use_zero_reg: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    idle();
    bus.EXMemRead = 1'b1; bus.EXrt = 5'd17; bus.IDrt = 5'd17; bus.IDUsesRt = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_LU) begin
      n_mis++;
      $display("FAIL load_use_rt: got %b want %b", ctl, C_LU);
    end
    next_cycle();
    bus.IDUsesRt = 1'b0;    // match exists but field is not read
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL load_use_unused_rt: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_md_stall();
    idle();
    bus.IDMulDiv = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL md_issue: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    bus.IDMulDiv = 1'b0; bus.IDReadHILO = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (ctl !== C_MDST) begin
        n_mis++;
        $display("FAIL mfhi_stall[%0d]: got %b want %b", c, ctl, C_MDST);
      end
      if (c == 1) begin
        n_cmp++;
        if (ctl1 !== C_MDST) begin
          n_mis++;
          $display("FAIL lat1_busy: got %b want %b", ctl1, C_MDST);
        end
      end
      if (c == 2) begin
        n_cmp++;
        if (ctl1 !== C_RUN) begin
          n_mis++;
          $display("FAIL lat1_done: got %b want %b", ctl1, C_RUN);
        end
      end
      next_cycle();
    end
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL mfhi_issue: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_branch();
    idle();
    bus.BranchTaken = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_BR) begin
      n_mis++;
      $display("FAIL branch_flush: got %b want %b", ctl, C_BR);
    end
    next_cycle();
    bus.EXMemRead = 1'b1; bus.EXrt = 5'd9; bus.IDrs = 5'd9; bus.IDUsesRs = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_LU) begin
      n_mis++;
      $display("FAIL branch_during_load_use: got %b want %b", ctl, C_LU);
    end
    next_cycle();
    idle();
  endtask

  task automatic test_overlap();
    idle();
    bus.IDMulDiv = 1'b1;
    next_cycle();
    // cycle 1: load-use and mult/div stall together
    idle();
    bus.IDReadHILO = 1'b1;
    bus.EXMemRead = 1'b1; bus.EXrt = 5'd3; bus.IDrs = 5'd3; bus.IDUsesRs = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_MDST) begin
      n_mis++;
      $display("FAIL lu_md_overlap: got %b want %b", ctl, C_MDST);
    end
    next_cycle();
    // cycle 2: unrelated branch while busy flushes normally
    idle();
    bus.BranchTaken = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_BRBUSY) begin
      n_mis++;
      $display("FAIL branch_while_busy: got %b want %b", ctl, C_BRBUSY);
    end
    next_cycle();
    idle();
    next_cycle();
    next_cycle();
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL overlap_drain: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    idle();
    bus.IDMulDiv = 1'b1;
    next_cycle();
    for (int c = 1; c <= 4; c++) begin
      @(negedge Clk);
      n_cmp++;
      if (ctl !== C_MDST) begin
        n_mis++;
        $display("FAIL b2b_hold[%0d]: got %b want %b", c, ctl, C_MDST);
      end
      next_cycle();
    end
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL b2b_second_issue: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    bus.IDMulDiv = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_BUSY) begin
      n_mis++;
      $display("FAIL b2b_busy_start: got %b want %b", ctl, C_BUSY);
    end
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_BUSY) begin
      n_mis++;
      $display("FAIL b2b_busy_last: got %b want %b", ctl, C_BUSY);
    end
    next_cycle();
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL b2b_done: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    // mult/div held by load-use must not start the timer
    bus.IDMulDiv = 1'b1;
    bus.EXMemRead = 1'b1; bus.EXrt = 5'd5; bus.IDrt = 5'd5; bus.IDUsesRt = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_LU) begin
      n_mis++;
      $display("FAIL md_blocked_by_lu: got %b want %b", ctl, C_LU);
    end
    next_cycle();
    idle();
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL md_not_issued: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
  endtask

  task automatic test_reset_mid_busy();
    idle();
    bus.IDMulDiv = 1'b1;
    next_cycle();
    idle();
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_BUSY) begin
      n_mis++;
      $display("FAIL midrst_busy: got %b want %b", ctl, C_BUSY);
    end
    next_cycle();
    Rst = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RST) begin
      n_mis++;
      $display("FAIL midrst_forced: got %b want %b", ctl, C_RST);
    end
    next_cycle();
    Rst = 1'b1;
    bus.IDReadHILO = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (ctl !== C_RUN) begin
      n_mis++;
      $display("FAIL midrst_mfhi_free: got %b want %b", ctl, C_RUN);
    end
    next_cycle();
    idle();
  endtask

`ifdef HAZARD_PERF_CNT_EN
  task automatic test_perf_counters();
    idle();
    Rst = 1'b0;
    next_cycle();
    Rst = 1'b1;
    @(negedge Clk);
    n_cmp++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_mis++;
      $display("FAIL perf_clear: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    bus.EXMemRead = 1'b1; bus.EXrt = 5'd12; bus.IDrs = 5'd12; bus.IDUsesRs = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
    idle();
    bus.BranchTaken = 1'b1;
    next_cycle();
    next_cycle();
    idle();
    @(negedge Clk);
    n_cmp++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 32'd2) begin
      n_mis++;
      $display("FAIL perf_count: got %0d/%0d want 3/2", stall_cnt, flush_cnt);
    end
    next_cycle();
    Rst = 1'b0;
    next_cycle();
    @(negedge Clk);
    n_cmp++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0) begin
      n_mis++;
      $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
    end
    Rst = 1'b1;
    next_cycle();
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_mis = 0;
    Rst   = 1'b0;
    idle();
    next_cycle();
    test_reset();
    test_load_use();
    test_md_stall();
    test_branch();
    test_overlap();
    test_back_to_back();
    test_reset_mid_busy();
`ifdef HAZARD_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
